usb_report_fifo: RTL and testbench
==================================

Name: usb_report_fifo

Overview:
Buffers USB HID reports for the SoC so that reports are no longer seen only as a raw, overwrite-prone bus. The block is parametrised in report size, queue depth, duplicate filtering and overflow policy. It sits between the HID host output and the SoC peripheral bus, and exposes a byte-addressable head entry with a pop strobe. Inputs are already synchronous to clk; CDC is handled upstream.

Parameters:
REPORT_BYTES, 8, bytes per HID report (1..64)
DEPTH, 4, number of queued reports; power of 2, 2..64
DEDUP, 1, 1: discard a report identical to the last enqueued one
OVERWRITE, 0, 0: when full, drop the incoming report; 1: when full, evict the oldest report
CNT_W, 16, width of the overflow counter

Ports:
clk  in  1  system clock
reset_ni  in  1  synchronous, active-low reset
report_i  in  REPORT_BYTES*8  report data; byte k = bits [8k+7:8k]
report_valid_i  in  1  report strobe or level; the rising edge captures
clear_i  in  1  synchronous flush
rd_req_i  in  1  pop the head entry (one per cycle)
byte_sel_i  in  $clog2(REPORT_BYTES)  head byte index
rd_data_o  out  8  head byte selected by byte_sel_i
empty_o  out  1  queue empty
full_o  out  1  queue full
count_o  out  $clog2(DEPTH+1)  occupancy
overflow_o  out  1  sticky: at least one report lost since reset/clear
overflow_cnt_o  out  CNT_W  lost-report count, saturating

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: empty_o=1, full_o=0, count_o=0, overflow_o=0, overflow_cnt_o=0, rd_data_o=0. Pointers are 0, the last-report memory is invalid, and the edge-detect register is 1, so a report_valid_i level held through reset is not captured.
- Capture: push_req = report_valid_i & !valid_q. report_i is sampled in that same cycle. A valid held high yields exactly one capture.
- Dedup (DEDUP=1): if the last-report memory is valid and report_i equals it, push_req is discarded silently. This is not an overflow.
- last-report memory updates only on an actual enqueue. It is invalidated by reset and by clear_i.
- Pop: when rd_req_i=1 and the queue is not empty, the head advances at the clock edge. rd_req_i while empty is ignored.
- rd_data_o is combinational from the head entry and byte_sel_i. It is forced to 0 when empty_o=1. If byte_sel_i >= REPORT_BYTES, rd_data_o=0.
- Latency: a push at edge N is reflected in count_o/empty_o after edge N. A report is poppable from cycle N+1. There is no bypass.
- Full, OVERWRITE=0, push with no pop: the report is dropped; overflow_o is set and overflow_cnt_o increments.
- Full, OVERWRITE=1, push with no pop: the oldest entry is evicted (head+1) and the new report is written at the tail. count_o stays DEPTH; overflow_o is set and the counter increments.
- Full with simultaneous push and pop: both happen, with no overflow and count unchanged. This applies in both modes.
- Empty with simultaneous push and pop: the pop is ignored and the push is accepted (count becomes 1).
- overflow_cnt_o saturates at 2^CNT_W-1.
- clear_i has priority over push and pop in the same cycle. It resets pointers, count, overflow_o, overflow_cnt_o and last-report memory. Storage contents are don't-care. A push_req in the clear cycle is discarded. The edge register still tracks report_valid_i.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from a separate count register of width $clog2(DEPTH+1).
- Reset asserted mid-operation behaves as clear, plus valid_q set to 1.

Decomposition:
- Package usb_report_pkg:
  - default REPORT_BYTES localparam
  - report_t typedef (logic [REPORT_BYTES*8-1:0])
  - byte-index width function
- Sub-module sync_fifo_ow: generic width/depth register-array FIFO with an overwrite-on-full option and count output.
- usb_report_fifo contains the edge detect, dedup compare, overflow accounting, byte mux and clear handling around sync_fifo_ow.

Test Plan:
- Reset release with report_valid_i held 1 and report 0x0000_0000_0004_0000 -> no capture; empty_o=1. Drop valid and re-raise -> count_o=1, byte_sel=2 gives rd_data_o=0x04.
- Default params, push reports R1..R4 (distinct), then R5 -> full_o=1, count_o=4, overflow_cnt_o=1. Pop 4 times -> byte 0 returns R1..R4 in order, then empty_o=1 and rd_data_o=0.
- OVERWRITE=1, push R1..R5 -> head is R2, count_o=4, overflow_o=1. A 6th push with simultaneous rd_req_i -> count_o stays 4, overflow_cnt_o stays 1.
- DEDUP=1, push A, A, B, A -> count_o=3 with order A, B, A. With DEDUP=0 the same sequence gives count_o=4.
- CNT_W=2, OVERWRITE=0, 5 pushes while full -> overflow_cnt_o saturates at 3. Then clear_i with a coincident push -> count_o=0, overflow_o=0, and the next identical report is accepted (memory invalid).
- Empty queue, push and rd_req_i in the same cycle -> count_o=1. rd_req_i on empty alone -> no pointer change; count_o stays 0.

Source files
------------

// File: rtl/usb_report_pkg.sv
// Shared types and helpers for the USB HID report queue.
package usb_report_pkg;

  localparam int DEFAULT_REPORT_BYTES = 8;

  typedef logic [DEFAULT_REPORT_BYTES*8-1:0] report_t;

  // Width of a byte index into an n-byte report; never narrower than one bit.
  function automatic int byte_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ow.sv
// Register-array FIFO with a separate occupancy counter and optional evict-oldest-on-full.
module sync_fifo_ow
  import usb_report_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             lost_o,
  output logic             accept_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;
  logic             over;
  logic             wr_en;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Work out pointer/count movement; a push into a full queue with no pop is either dropped or evicts the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    pop_ok   = pop_i & ~empty_o;
    over     = push_i & full_o & ~pop_ok;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (over) begin
      if (OVERWRITE) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end else begin
      if (push_i) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  assign lost_o   = over & ~clear_i;
  assign accept_o = wr_en;
  assign count_o  = count_q;

  // Storage is not reset; contents behind the pointers are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/usb_report_fifo.sv
// HID report queue: rising-edge capture, duplicate filter, loss accounting and byte-addressable head.
module usb_report_fifo
  import usb_report_pkg::*;
#(
  parameter int REPORT_BYTES = DEFAULT_REPORT_BYTES,
  parameter int DEPTH        = 4,
  parameter bit DEDUP        = 1'b1,
  parameter bit OVERWRITE    = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_ni,
  input  logic [REPORT_BYTES*8-1:0]            report_i,
  input  logic                                 report_valid_i,
  input  logic                                 clear_i,
  input  logic                                 rd_req_i,
  input  logic [byte_idx_w(REPORT_BYTES)-1:0]  byte_sel_i,
  output logic [7:0]                           rd_data_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [$clog2(DEPTH+1)-1:0]           count_o,
  output logic                                 overflow_o,
  output logic [CNT_W-1:0]                     overflow_cnt_o
);

  localparam int RW = REPORT_BYTES * 8;

  logic             valid_q, valid_d;
  logic [RW-1:0]    last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic             push_req;
  logic             is_dup;
  logic             push;
  logic             pop;
  logic [RW-1:0]    head;
  logic             fifo_lost;
  logic             fifo_accept;
  logic             fifo_empty;

  // Edge detect and duplicate filter decide whether this cycle offers a report to the queue.
  always_comb begin
    push_req = report_valid_i & ~valid_q;
    is_dup   = DEDUP & last_vld_q & (report_i == last_q);
    push     = push_req & ~is_dup & ~clear_i;
    pop      = rd_req_i & ~clear_i;
  end

  sync_fifo_ow #(
    .WIDTH     (RW),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clear_i  (clear_i),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_i  (report_i),
    .head_o   (head),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (fifo_empty),
    .lost_o   (fifo_lost),
    .accept_o (fifo_accept)
  );

  // Next-state for the edge register, last-report memory and saturating loss counter.
  always_comb begin
    valid_d    = report_valid_i;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (clear_i) begin
      last_vld_d = 1'b0;
      overflow_d = 1'b0;
      ovf_cnt_d  = '0;
    end else begin
      if (fifo_accept) begin
        last_d     = report_i;
        last_vld_d = 1'b1;
      end
      if (fifo_lost) begin
        overflow_d = 1'b1;
        if (ovf_cnt_q != {CNT_W{1'b1}}) begin
          ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
      end
    end
  end

  // Edge register resets high so a valid level held through reset is not taken as a new report.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      valid_q    <= 1'b1;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Byte mux over the head entry; reads as zero when empty or the index is past the report.
  always_comb begin
    rd_data_o = 8'h00;
    for (int k = 0; k < REPORT_BYTES; k++) begin
      if (!fifo_empty && (int'(byte_sel_i) == k)) begin
        rd_data_o = head[k*8 +: 8];
      end
    end
  end

  assign empty_o        = fifo_empty;
  assign overflow_o     = overflow_q;
  assign overflow_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_usb_report_fifo.sv
// Bench for usb_report_fifo: default, overwrite, no-dedup and narrow-counter variants share one stimulus stream.
module tb_usb_report_fifo;
  import usb_report_pkg::*;

  logic       clk = 1'b0;
  logic       reset_ni;
  report_t    report_i;
  logic       report_valid_i;
  logic       clear_i;
  logic       rd_req_i;
  logic [2:0] byte_sel_i;

  logic [7:0]  d_rd, o_rd, n_rd, c_rd;
  logic        d_empty, o_empty, n_empty, c_empty;
  logic        d_full, o_full, n_full, c_full;
  logic [2:0]  d_count, o_count, n_count, c_count;
  logic        d_ovf, o_ovf, n_ovf, c_ovf;
  logic [15:0] d_cnt, o_cnt, n_cnt;
  logic [1:0]  c_cnt;

  int errors = 0;
  int checks = 0;

  report_t     m_q[$];
  logic        m_vq;
  logic        m_lv;
  logic        m_ovf;
  logic [15:0] m_cnt;
  report_t     m_last;

  typedef struct {
    logic       v;
    report_t    r;
    logic       c;
    logic       rd;
    logic [2:0] sel;
    int         ecnt;
    int         encnt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  usb_report_fifo u_def (
    .clk(clk), .reset_ni(reset_ni), .report_i(report_i), .report_valid_i(report_valid_i),
    .clear_i(clear_i), .rd_req_i(rd_req_i), .byte_sel_i(byte_sel_i), .rd_data_o(d_rd),
    .empty_o(d_empty), .full_o(d_full), .count_o(d_count), .overflow_o(d_ovf),
    .overflow_cnt_o(d_cnt));

  usb_report_fifo #(.OVERWRITE(1'b1)) u_ow (
    .clk(clk), .reset_ni(reset_ni), .report_i(report_i), .report_valid_i(report_valid_i),
    .clear_i(clear_i), .rd_req_i(rd_req_i), .byte_sel_i(byte_sel_i), .rd_data_o(o_rd),
    .empty_o(o_empty), .full_o(o_full), .count_o(o_count), .overflow_o(o_ovf),
    .overflow_cnt_o(o_cnt));

  usb_report_fifo #(.DEDUP(1'b0)) u_nd (
    .clk(clk), .reset_ni(reset_ni), .report_i(report_i), .report_valid_i(report_valid_i),
    .clear_i(clear_i), .rd_req_i(rd_req_i), .byte_sel_i(byte_sel_i), .rd_data_o(n_rd),
    .empty_o(n_empty), .full_o(n_full), .count_o(n_count), .overflow_o(n_ovf),
    .overflow_cnt_o(n_cnt));

  usb_report_fifo #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset_ni(reset_ni), .report_i(report_i), .report_valid_i(report_valid_i),
    .clear_i(clear_i), .rd_req_i(rd_req_i), .byte_sel_i(byte_sel_i), .rd_data_o(c_rd),
    .empty_o(c_empty), .full_o(c_full), .count_o(c_count), .overflow_o(c_ovf),
    .overflow_cnt_o(c_cnt));

  // Distinct reports differ in byte 0; the upper bytes give the byte mux something to select.
  function automatic report_t rep(input logic [7:0] k);
    return {56'hA5_5A_0F_F0_33_CC_01, k};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] k, input logic c,
                              input logic rd, input logic [2:0] sel, input int ec, input int en);
    vec_t t;
    t.v = v; t.r = rep(k); t.c = c; t.rd = rd; t.sel = sel; t.ecnt = ec; t.encnt = en;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the head byte against the scoreboard before the edge, update the model, check state after.
  task automatic applyStimulus(input logic v, input report_t r, input logic c,
                               input logic rd, input logic [2:0] sel);
    logic    push_req;
    logic    dup;
    logic    pop;
    report_t head;
    logic [7:0] exp_b;
    @(negedge clk);
    report_valid_i = v;
    report_i       = r;
    clear_i        = c;
    rd_req_i       = rd;
    byte_sel_i     = sel;
    #1;
    push_req = v & ~m_vq;
    dup      = m_lv && (r == m_last);
    m_vq     = v;
    if (rd) begin
      exp_b = 8'h00;
      if (m_q.size() > 0) begin
        head  = m_q[0];
        exp_b = head[sel*8 +: 8];
      end
      checkOutput("rd_data", 32'(d_rd), 32'(exp_b));
    end
    if (c) begin
      m_q.delete();
      m_lv  = 1'b0;
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      pop = rd && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (push_req && !dup) begin
        if (m_q.size() >= 4) begin
          m_ovf = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt++;
        end else begin
          m_q.push_back(r);
          m_last = r;
          m_lv   = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput("count", 32'(d_count), 32'(m_q.size()));
    checkOutput("empty", 32'(d_empty), 32'(m_q.size() == 0));
    checkOutput("full", 32'(d_full), 32'(m_q.size() == 4));
    checkOutput("overflow", 32'(d_ovf), 32'(m_ovf));
    checkOutput("overflow_cnt", 32'(d_cnt), 32'(m_cnt));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_ni       = 1'b0;
    report_valid_i = 1'b1;
    report_i       = 64'h0000_0000_0004_0000;
    clear_i        = 1'b0;
    rd_req_i       = 1'b0;
    byte_sel_i     = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete();
    m_vq  = 1'b1;
    m_lv  = 1'b0;
    m_ovf = 1'b0;
    m_cnt = '0;
    checkOutput("rst_empty", 32'(d_empty), 32'd1);
    checkOutput("rst_full", 32'(d_full), 32'd0);
    checkOutput("rst_count", 32'(d_count), 32'd0);
    checkOutput("rst_overflow", 32'(d_ovf), 32'd0);
    checkOutput("rst_overflow_cnt", 32'(d_cnt), 32'd0);
    checkOutput("rst_rd_data", 32'(d_rd), 32'd0);
    checkOutput("rst_ow_empty", 32'(o_empty), 32'd1);
    checkOutput("rst_c2_cnt", 32'(c_cnt), 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_ni       = 1'b0;
    report_valid_i = 1'b1;
    report_i       = '0;
    clear_i        = 1'b0;
    rd_req_i       = 1'b0;
    byte_sel_i     = '0;

    // Level held through reset must not capture; re-raising it must.
    doReset();
    applyStimulus(1'b1, 64'h0000_0000_0004_0000, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b0, 64'h0000_0000_0004_0000, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b1, 64'h0000_0000_0004_0000, 1'b0, 1'b0, 3'd2);
    checkOutput("rst_recapture_byte2", 32'(d_rd), 32'h04);
    applyStimulus(1'b0, 64'h0000_0000_0004_0000, 1'b0, 1'b1, 3'd2);

    // Fill/overflow/drain, pop on empty, empty push+pop, dedup, full push+pop.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 2, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 3));
    tbl.push_back(mk(0, 3, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4, 0, 0, 0, 4, 4));
    tbl.push_back(mk(0, 4, 0, 0, 0, 4, 4));
    tbl.push_back(mk(1, 5, 0, 0, 0, 4, 4));
    tbl.push_back(mk(0, 5, 0, 1, 0, 3, 3));
    tbl.push_back(mk(0, 5, 0, 1, 7, 2, 2));
    tbl.push_back(mk(0, 5, 0, 1, 3, 1, 1));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 6, 0, 1, 5, 0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 7, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 7, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 8, 0, 0, 0, 2, 3));
    tbl.push_back(mk(0, 8, 0, 0, 0, 2, 3));
    tbl.push_back(mk(1, 7, 0, 0, 0, 3, 4));
    tbl.push_back(mk(0, 7, 0, 1, 0, 2, 3));
    tbl.push_back(mk(0, 7, 0, 1, 0, 1, 2));
    tbl.push_back(mk(0, 7, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 2, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 2, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 3));
    tbl.push_back(mk(0, 3, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4, 0, 0, 0, 4, 4));
    tbl.push_back(mk(0, 4, 0, 0, 0, 4, 4));
    tbl.push_back(mk(1, 5, 0, 1, 0, 4, 4));
    tbl.push_back(mk(0, 5, 0, 0, 0, 4, 4));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].rd, tbl[i].sel);
      checkOutput($sformatf("tbl%0d_count", i), 32'(d_count), 32'(tbl[i].ecnt));
      checkOutput($sformatf("tbl%0d_nodedup_count", i), 32'(n_count), 32'(tbl[i].encnt));
    end
    checkOutput("tbl_end_overflow_cnt", 32'(d_cnt), 32'd0);

    // Overwrite mode: fifth push evicts the oldest; push+pop while full is lossless.
    applyStimulus(1'b0, rep(0), 1'b1, 1'b0, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, rep(8'(k)), 1'b0, 1'b0, 3'd0);
      applyStimulus(1'b0, rep(8'(k)), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("ow_count", 32'(o_count), 32'd4);
    checkOutput("ow_full", 32'(o_full), 32'd1);
    checkOutput("ow_overflow", 32'(o_ovf), 32'd1);
    checkOutput("ow_overflow_cnt", 32'(o_cnt), 32'd1);
    checkOutput("ow_head", 32'(o_rd), 32'h02);
    applyStimulus(1'b1, rep(6), 1'b0, 1'b1, 3'd0);
    checkOutput("ow_pushpop_count", 32'(o_count), 32'd4);
    checkOutput("ow_pushpop_overflow_cnt", 32'(o_cnt), 32'd1);
    checkOutput("ow_pushpop_head", 32'(o_rd), 32'h03);

    // Narrow counter saturates; clear beats a coincident push and forgets the last report.
    applyStimulus(1'b0, rep(0), 1'b1, 1'b0, 3'd0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, rep(8'(k)), 1'b0, 1'b0, 3'd0);
      applyStimulus(1'b0, rep(8'(k)), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("c2_count", 32'(c_count), 32'd4);
    checkOutput("c2_overflow", 32'(c_ovf), 32'd1);
    checkOutput("c2_overflow_cnt_sat", 32'(c_cnt), 32'd3);
    applyStimulus(1'b1, rep(4), 1'b1, 1'b0, 3'd0);
    checkOutput("c2_clear_count", 32'(c_count), 32'd0);
    checkOutput("c2_clear_empty", 32'(c_empty), 32'd1);
    checkOutput("c2_clear_overflow", 32'(c_ovf), 32'd0);
    checkOutput("c2_clear_overflow_cnt", 32'(c_cnt), 32'd0);
    applyStimulus(1'b0, rep(4), 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, rep(4), 1'b0, 1'b0, 3'd0);
    checkOutput("c2_after_clear_count", 32'(c_count), 32'd1);
    checkOutput("c2_after_clear_head", 32'(c_rd), 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
